clk_div_n: RTL
==============

Name: clk_div_n

Overview:
- Parametrised, runtime-programmable clock divider. Successor to the fixed divide-by-6 generator.
- Divide ratio is loaded over a simple strobe interface.
- Start, stop and ratio changes are glitch-free: they take effect only at a period boundary.
- Produces a divided clock plus a one-cycle tick aligned to each period start, for downstream logic in the clk domain.

Parameters:
- CNT_W, 8, width of the divide-ratio and counter registers; legal ratio 2..2^CNT_W-1.
- DEFAULT_DIV, 6, ratio active after reset; must be in 2..2^CNT_W-1.

Ports:
- clk  input  1  source clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  run request; level-sensitive.
- div_val  input  CNT_W  requested divide ratio N.
- div_load  input  1  one-cycle strobe capturing div_val.
- clk_out  output  1  divided clock.
- tick  output  1  one-cycle pulse on the first clk cycle of each clk_out period.
- div_cur  output  CNT_W  ratio currently in force.
- running  output  1  high in RUN or STOPPING.
- err  output  1  sticky; set when an illegal ratio (0 or 1) is loaded.

Behaviour:
- Clocking/reset: single clock clk; reset is asynchronous and active-low on reset_n.
- Reset values: cnt=0, clk_out=0, tick=0, div_cur=DEFAULT_DIV, pend=DEFAULT_DIV, state=IDLE, running=0, err=0.
- Registers: cnt[CNT_W-1:0] counts 0..N-1 (N = div_cur); pend holds a loaded ratio not yet applied; H = floor(N/2).
- Base output q_pos is registered: q_pos <= (cnt_next < H), where cnt_next is the value cnt takes at the same edge.
- Resulting waveform: N even gives N/2 high, N/2 low. N odd without the optional feature gives (N-1)/2 high, (N+1)/2 low.
- Wrap edge: any edge where cnt==N-1 in RUN or STOPPING; cnt_next=0 at that edge.
- States:
  - IDLE: cnt=0, clk_out=0, tick=0. On an edge with en=1, go to RUN: cnt<=0, q_pos<=1, tick<=1. Latency from en sampled high to clk_out high is 1 edge.
  - RUN: cnt increments each edge and wraps to 0 at N-1. tick<=1 exactly on each wrap edge, 0 otherwise. en=0 at a non-wrap edge moves to STOPPING.
  - STOPPING: counts exactly as RUN; the current period always completes. en=1 returns to RUN with no interruption to counting. At the wrap edge: if en=0, go to IDLE with cnt<=0, q_pos<=0, tick<=0; if en=1, continue in RUN.
  - Wrap edge with en=0 from RUN: go directly to IDLE.
- Ratio update:
  - div_load=1 stores the clamped value into pend: values 0 or 1 store 2 and set err.
  - div_cur<=pend at every wrap edge, and immediately in IDLE.
  - div_load coincident with a wrap edge, or while in IDLE: the new value goes straight to div_cur at that edge.
  - Loads during a period never alter the current period's length or duty.
  - Back-to-back loads: the last one before the wrap wins.
- Counter width: cnt compare is unsigned CNT_W bits; no overflow is possible because N ≤ 2^CNT_W-1.
- running = (state != IDLE).
- Reset mid-period: clk_out drops to 0 immediately (asynchronous); all state returns to reset values.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- When defined: a negedge-clk flop q_neg samples q_pos, and for odd N clk_out = q_pos | q_neg.
  - Gives (N/2) cycles high, exactly 50% duty; the falling edge lands on a clk falling edge.
  - For even N, clk_out = q_pos (q_neg is ignored).
  - q_neg resets to 0 asynchronously on reset_n.
- When undefined: clk_out = q_pos for all N; no negedge logic is instantiated; odd N gives the low-biased duty above.

Test Plan:
- Reset, default ratio: reset_n low then high, en=1 → clk_out high 3 / low 3 cycles; tick every 6 clk; div_cur=6; running=1.
- Odd ratio: load 5 in IDLE, en=1.
  - Without macro: clk_out high 2 / low 3.
  - With CLK_DIV_ODD_DUTY50_EN: high 2.5 / low 2.5 clk periods.
  - tick period 5 in both builds.
- Mid-period load: running N=8; pulse div_load with div_val=4 at cnt=2 → current period stays 8 cycles; from the next tick, period is 4; div_cur changes on the wrap edge.
- Glitch-free stop: N=6; drop en at cnt=1 → STOPPING; clk_out completes its 3-low phase; IDLE at the wrap; no further tick. Re-raise en during STOPPING (separate run) → no gap between periods.
- Illegal ratio: load 0, then 1 → div_cur=2 after wrap; clk_out toggles every clk; err=1 and stays 1 after a legal load of 10.
- Async reset mid-operation: assert reset_n at cnt=3 with N=10, between clk edges → clk_out, tick and running go 0 immediately; div_cur=6 after release.

Source files
------------

// File: rtl/clk_div_n.sv
`default_nettype none
// ============================================================================
// clk_div_n : runtime-programmable clock divider with glitch-free start, stop
// and ratio changes. Optional CLK_DIV_ODD_DUTY50_EN gives 50% duty on odd N.
// Rev 1.0
// ============================================================================
module clk_div_n #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             running,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             q_pos_q, q_pos_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;

  always_comb begin
    load_val  = (div_val < DIV_MIN) ? DIV_MIN : div_val;
    half      = div_cur_q >> 1;
    cnt_inc   = cnt_q + CNT_W'(1);
    wrap      = (state_q != IDLE) && (cnt_q == div_cur_q - CNT_W'(1));

    pend_d    = div_load ? load_val : pend_q;
    err_d     = err_q | (div_load && (div_val < DIV_MIN));
    // A new ratio only takes hold at a period boundary (or while idle).
    div_cur_d = (state_q == IDLE || wrap) ? pend_d : div_cur_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    q_pos_d   = q_pos_q;
    tick_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        q_pos_d = 1'b0;
        if (en) begin
          state_d = RUN;
          q_pos_d = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cnt_d = '0;
          if (en) begin
            state_d = RUN;
            q_pos_d = 1'b1;
            tick_d  = 1'b1;
          end else begin
            state_d = IDLE;
            q_pos_d = 1'b0;
          end
        end else begin
          // Stopping still finishes the current period before going idle.
          cnt_d   = cnt_inc;
          q_pos_d = (cnt_inc < half);
          state_d = en ? RUN : STOPPING;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        q_pos_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_cur_q <= DIV_RST;
      pend_q    <= DIV_RST;
      q_pos_q   <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      q_pos_q   <= q_pos_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic q_neg_q;
  logic q_neg_d;

  assign q_neg_d = q_pos_q;

  // Half-cycle delayed copy stretches the high phase by half a clk on odd N.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
    end
  end

  assign clk_out = div_cur_q[0] ? (q_pos_q | q_neg_q) : q_pos_q;
`else
  assign clk_out = q_pos_q;
`endif

  assign tick    = tick_q;
  assign div_cur = div_cur_q;
  assign running = (state_q != IDLE);
  assign err     = err_q;

endmodule
`default_nettype wire
